// File: rtl/tiny8_mem_ctrl.sv
// Memory-side responder for the tiny8 core: runs a fixed-wait-state access on an async SRAM per request.
// Latency: request sampled in cycle 0, ACCESS for WAIT_CYCLES+1 cycles, mem_resp in cycle WAIT_CYCLES+2.
// Backpressure: request is level-held by the core; it is sampled only in IDLE and ignored during ACCESS/DONE.
module tiny8_mem_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  proto_err,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic                  sram_oe
);

    // Wait count loaded on accept; only 0..15 fits the 4-bit counter.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wcnt;
    logic [3:0] wcnt_nxt;
    logic       op_write;

    logic       req;
    logic       accept;
    logic       last_beat;

    // Request qualification: only IDLE samples the core's level-held strobes.
    assign req       = mem_read | mem_write;
    assign accept    = (state == ST_IDLE) && req;
    assign last_beat = (state == ST_ACCESS) && (wcnt == 4'd0);

    // State and wait-counter registers; reset discards any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state logic: IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE (one cycle) -> IDLE.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_ACCESS;
                    wcnt_nxt  = WAIT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (wcnt != 4'd0) begin
                    wcnt_nxt = wcnt - 4'd1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // A request still held here belongs to the access just finished.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    // Latch address, data and operation once per access so the SRAM side stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            op_write   <= 1'b0;
        end else if (accept) begin
            sram_addr  <= mem_address;
            sram_wdata <= mem_wdata;
            // Simultaneous read+write is resolved as a write.
            op_write   <= mem_write;
        end
    end

    // Capture read data at the edge closing the last ACCESS cycle; writes leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= '0;
        end else if (last_beat && !op_write) begin
            mem_rdata <= sram_rdata;
        end
    end

    // Sticky protocol error for read and write sampled together; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (accept && mem_read && mem_write) begin
            proto_err <= 1'b1;
        end
    end

    // Strobes and response decoded from registered state only: no input-to-output path.
    always_comb begin
        sram_ce  = (state == ST_ACCESS);
        sram_we  = (state == ST_ACCESS) && op_write;
        sram_oe  = (state == ST_ACCESS) && !op_write;
        mem_resp = (state == ST_DONE);
    end

endmodule

// File: doc/tiny8_mem_ctrl.md
# tiny8_mem_ctrl

Memory-side responder for the tiny8 multicycle core. Sits directly downstream of the control FSM and datapath. Accepts the level-held `mem_read` / `mem_write` request together with the datapath address and write data, and runs a fixed-wait-state access on an external asynchronous SRAM. It returns read data plus a single-cycle `mem_resp` pulse that releases the FSM from its FETCH2, LDP_2 and STP_3 wait loops.

## Interface
- `ADDR_WIDTH`, default 16: width of the byte address.
- `DATA_WIDTH`, default 8: memory word width.
- `WAIT_CYCLES`, default 2: extra SRAM access cycles; legal range 0..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  read request, held high by the FSM until it sees `mem_resp`.
- `mem_write`  in  1  write request, held the same way.
- `mem_address`  in  ADDR_WIDTH  request address, from MAR.
- `mem_wdata`  in  DATA_WIDTH  write data, from MDR.
- `mem_rdata`  out  DATA_WIDTH  registered read data; valid when `mem_resp`=1.
- `mem_resp`  out  1  one-cycle completion pulse.
- `proto_err`  out  1  sticky flag; set when read and write are sampled together.
- `sram_addr`  out  ADDR_WIDTH  SRAM address, registered.
- `sram_wdata`  out  DATA_WIDTH  SRAM write data, registered.
- `sram_rdata`  in  DATA_WIDTH  SRAM read data.
- `sram_ce`  out  1  chip enable, active-high.
- `sram_we`  out  1  write enable, active-high.
- `sram_oe`  out  1  output enable, active-high.

## Operation
- States: IDLE, ACCESS, DONE. A 4-bit wait counter `wcnt` runs during ACCESS.
- **IDLE**
  - No SRAM strobes asserted.
  - If `mem_read|mem_write` is high at a rising edge:
    - latch `mem_address` → `sram_addr`;
    - latch `mem_wdata` → `sram_wdata`;
    - latch the operation (write if `mem_write`=1, else read);
    - load `wcnt` = WAIT_CYCLES and go to ACCESS.
- **ACCESS**
  - Strobes: `sram_ce`=1; `sram_we`=op_write; `sram_oe`=!op_write.
  - While `wcnt`≠0: decrement `wcnt` and stay.
  - When `wcnt`=0:
    - for a read, capture `sram_rdata` → `mem_rdata`;
    - go to DONE.
  - ACCESS therefore lasts exactly WAIT_CYCLES+1 cycles.
- **DONE**
  - `mem_resp`=1 for this one cycle; all strobes 0.
  - Unconditionally go to IDLE. A request still high during DONE is not sampled.
  - Consequence: a new request is accepted no earlier than the cycle after DONE. This matches the FSM, which drops the request in the cycle after `mem_resp`.
- **Latching**
  - Address, data and operation are latched once per access.
  - Changes on the request inputs during ACCESS/DONE are ignored.
  - Deasserting the request mid-ACCESS does not abort the access. The access completes and `mem_resp` still pulses.
- **Simultaneous read and write** (both sampled in IDLE):
  - performed as a write;
  - `proto_err` set to 1, cleared only by `rst`.
- `mem_rdata` holds the last read value. Writes never modify it.

## Timing
- Reset value of every output is 0: `mem_rdata`, `mem_resp`, `proto_err`, `sram_addr`, `sram_wdata`, `sram_ce`, `sram_we`, `sram_oe`. State → IDLE, `wcnt` → 0.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_read`, `mem_write` or `sram_rdata` to any output.
- Latency: request first high in cycle 0 (in IDLE) → ACCESS in cycles 1..WAIT_CYCLES+1 → `mem_resp` in cycle WAIT_CYCLES+2.
  - WAIT_CYCLES=2: `mem_resp` in cycle 4.
  - WAIT_CYCLES=0: `mem_resp` in cycle 2.
- Throughput: one access per WAIT_CYCLES+3 cycles at best. IDLE always separates accesses by at least one cycle.
- `sram_addr` and `sram_wdata` are stable for the whole ACCESS window. `sram_we` is high for exactly WAIT_CYCLES+1 cycles.
- Read sampling: `sram_rdata` is sampled at the rising edge that ends the last ACCESS cycle.
- Reset asserted mid-ACCESS:
  - strobes drop to 0 asynchronously;
  - no `mem_resp` is produced;
  - the pending access is discarded.
- Reset asserted during DONE: `mem_resp` drops immediately.

## Test plan
1. **Read, default parameters.** WAIT_CYCLES=2; SRAM model returns 0x5A at 0x0010; hold `mem_read`=1 with `mem_address`=0x0010 from cycle 0 → `sram_ce`/`sram_oe`=1 in cycles 1–3, `mem_resp`=1 only in cycle 4 with `mem_rdata`=0x5A, `mem_resp`=0 in cycle 5.
2. **Write then readback.** `mem_write` with address 0x00FF, data 0xC3 → `sram_we`=1 for exactly 3 cycles with `sram_wdata`=0xC3 and `mem_resp` pulses once. A following read of 0x00FF returns 0xC3, and `mem_rdata` does not change during the write.
3. **Zero wait states, back-to-back.** WAIT_CYCLES=0; read, then FSM-style release and re-request in the cycle after `mem_resp` → each `mem_resp` comes 2 cycles after its request; accesses start 3 cycles apart; no double-accept while the request is still high in DONE.
4. **Latching.** Change `mem_address` 0x0010→0x0020 and drop `mem_read` in cycle 2 → `sram_addr` stays 0x0010 throughout and `mem_resp` still pulses in cycle 4.
5. **Protocol error.** `mem_read`=`mem_write`=1 in IDLE → write performed (`sram_we`=1) and `proto_err`=1 from the next cycle. `proto_err` stays 1 across later clean accesses and clears only on `rst`.
6. **Reset mid-access.** Assert `rst` in cycle 2 of a read → all outputs 0 within that cycle, no `mem_resp`. After release, a new read completes normally with full latency.
